// File: rtl/lc_cfg_sequencer.sv
// lc_cfg_sequencer: shadow store of per-cell config words plus the programming
// sequence for an iCE40UP logic-cell chain (purst pulse, serial shift, prog strobe).
module lc_cfg_sequencer #(
  parameter int NUM_CELLS    = 8,
  parameter int CBIT_W       = 21,
  parameter int PURST_CYCLES = 4,
  parameter int AW           = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [CBIT_W-1:0] cfg_data,
  input  logic              commit,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              lc_purst,
  output logic              lc_prog,
  output logic              lc_shift_en,
  output logic              lc_sdata
);
  // state  | meaning
  // IDLE   | accepting writes and commit
  // RST    | lc_purst held for PURST_CYCLES
  // SHIFT  | image shifted out, MSB (cell NUM_CELLS-1, bit 20) first
  // PROG   | one-cycle lc_prog strobe
  // DONE   | completion pulse; writes/commit already accepted again

  localparam int TOTAL = NUM_CELLS * CBIT_W;
  localparam int BW    = $clog2(TOTAL + 1);

  typedef enum logic [2:0] {S_IDLE, S_RST, S_SHIFT, S_PROG, S_DONE} state_t;
  state_t state, state_next;

  logic [CBIT_W-1:0] shadow [NUM_CELLS];
  logic [TOTAL-1:0]  image;
  logic [TOTAL-1:0]  sreg;
  logic [7:0]        rst_cnt;
  logic [BW-1:0]     bit_cnt;
  logic              open_win;
  logic              wr_acc;
  logic              addr_ok;
  logic              commit_acc;

  assign open_win   = (state == S_IDLE) || (state == S_DONE);
  assign wr_acc     = cfg_valid && open_win;
  assign addr_ok    = int'(cfg_addr) < NUM_CELLS;
  assign commit_acc = commit && open_win;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_CELLS; i++) shadow[i] <= '0;
    end else if (wr_acc && addr_ok) begin
      for (int i = 0; i < NUM_CELLS; i++)
        if (cfg_addr == AW'(i)) shadow[i] <= cfg_data;
    end
  end

  // Cell 0 sits at the LSB end so the highest cell leaves the chain first.
  always_comb begin
    image = '0;
    for (int i = 0; i < NUM_CELLS; i++) image[i*CBIT_W +: CBIT_W] = shadow[i];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE, S_DONE: state_next = commit_acc ? S_RST : S_IDLE;
      S_RST:   if (rst_cnt == 8'(PURST_CYCLES - 1)) state_next = S_SHIFT;
      S_SHIFT: if (bit_cnt == BW'(TOTAL - 1)) state_next = S_PROG;
      S_PROG:  state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rst_cnt <= '0;
      bit_cnt <= '0;
      sreg    <= '0;
      err     <= 1'b0;
    end else begin
      rst_cnt <= (state == S_RST)   ? rst_cnt + 8'd1   : 8'd0;
      bit_cnt <= (state == S_SHIFT) ? bit_cnt + BW'(1) : '0;
      if (state == S_RST && state_next == S_SHIFT) sreg <= image;
      else if (state == S_SHIFT)                   sreg <= {sreg[TOTAL-2:0], 1'b0};
      err <= (wr_acc && !addr_ok) || (commit && !open_win);
    end
  end

  assign cfg_ready   = open_win;
  assign busy        = (state == S_RST) || (state == S_SHIFT) || (state == S_PROG);
  assign done        = (state == S_DONE);
  assign lc_purst    = (state == S_RST);
  assign lc_shift_en = (state == S_SHIFT);
  assign lc_prog     = (state == S_PROG);
  assign lc_sdata    = sreg[TOTAL-1];

endmodule

// File: tb/tb_lc_cfg_sequencer.sv
// Scoreboard bench for lc_cfg_sequencer: default instance (N=8, P=4, 4-bit
// address so out-of-range cells are reachable) and a corner instance (N=1, P=1).
module tb_lc_cfg_sequencer;
  localparam int N = 8;
  localparam int P = 4;
  localparam int W = 21;
  localparam int T = N * W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        cfg_valid, cfg_ready, commit, busy, done, err;
  logic        lc_purst, lc_prog, lc_shift_en, lc_sdata;
  logic [3:0]  cfg_addr;
  logic [20:0] cfg_data;

  logic        c_valid, c_ready, c_commit, c_busy, c_done, c_err;
  logic        c_purst, c_prog, c_shift, c_sdata;
  logic [0:0]  c_addr;
  logic [20:0] c_data;

  lc_cfg_sequencer #(.NUM_CELLS(N), .PURST_CYCLES(P), .AW(4)) dut (
    .clk(clk), .resetn(resetn), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .commit(commit), .busy(busy),
    .done(done), .err(err), .lc_purst(lc_purst), .lc_prog(lc_prog),
    .lc_shift_en(lc_shift_en), .lc_sdata(lc_sdata));

  lc_cfg_sequencer #(.NUM_CELLS(1), .PURST_CYCLES(1)) dut_c (
    .clk(clk), .resetn(resetn), .cfg_valid(c_valid), .cfg_ready(c_ready),
    .cfg_addr(c_addr), .cfg_data(c_data), .commit(c_commit), .busy(c_busy),
    .done(c_done), .err(c_err), .lc_purst(c_purst), .lc_prog(c_prog),
    .lc_shift_en(c_shift), .lc_sdata(c_sdata));

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [20:0] shadow_m [N];
  bit          exp_q [$];
  bit          cq [$];

  task automatic push_image();
    for (int c = N - 1; c >= 0; c--)
      for (int b = W - 1; b >= 0; b--) exp_q.push_back(shadow_m[c][b]);
  endtask

  // Scoreboard consumer: every shifted bit must match the next expected bit.
  always @(negedge clk) begin
    if (resetn && lc_shift_en) begin
      if (exp_q.size() == 0) check("sdata_underflow", {31'b0, lc_shift_en}, 32'd0);
      else                   check("sdata", {31'b0, lc_sdata}, {31'b0, exp_q.pop_front()});
    end
  end

  task automatic wr(input logic [3:0] a, input logic [20:0] d);
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    check("wr_ready", {31'b0, cfg_ready}, 32'd1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    if (a < 4'(N)) shadow_m[a[2:0]] = d;
    @(negedge clk);
    check("wr_err", {31'b0, err}, {31'b0, (a >= 4'(N))});
  endtask

  task automatic run_seq(input int inj_commit, input int inj_valid, input int rst_at,
                         input bit wr_same, input logic [3:0] wa, input logic [20:0] wd);
    logic [6:0] exp;
    @(posedge clk); #1;
    commit = 1'b1;
    if (wr_same) begin
      cfg_valid = 1'b1; cfg_addr = wa; cfg_data = wd;
      shadow_m[wa[2:0]] = wd;
    end
    push_image();
    @(posedge clk); #1;
    commit = 1'b0; cfg_valid = 1'b0;
    for (int cyc = 1; cyc <= P + T + 3; cyc++) begin
      commit = (cyc == inj_commit);
      if (cyc == inj_valid) begin
        cfg_valid = 1'b1; cfg_addr = 4'd2; cfg_data = 21'h155555;
      end else begin
        cfg_valid = 1'b0;
      end
      @(negedge clk);
      if (cyc == rst_at) begin
        resetn = 1'b0;
        #1;
        check("rst_async_outs", {25'b0, busy, done, err, lc_purst, lc_prog, lc_shift_en, lc_sdata}, 32'd0);
        exp_q.delete();
        for (int i = 0; i < N; i++) shadow_m[i] = '0;
        commit = 1'b0; cfg_valid = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
          check("rst_no_prog", {31'b0, lc_prog}, 32'd0);
        end
        resetn = 1'b1;
        @(negedge clk);
        check("rst_release", {25'b0, cfg_ready, busy, done, err, lc_purst, lc_prog, lc_shift_en}, 32'h40);
        return;
      end
      exp = {cyc >= P + T + 2, cyc <= P + T + 1, cyc <= P,
             (cyc > P) && (cyc <= P + T), cyc == P + T + 1, cyc == P + T + 2,
             (inj_commit > 0) && (cyc == inj_commit + 1)};
      check($sformatf("seq_c%0d", cyc),
            {25'b0, cfg_ready, busy, lc_purst, lc_shift_en, lc_prog, done, err}, {25'b0, exp});
      @(posedge clk); #1;
    end
    commit = 1'b0; cfg_valid = 1'b0;
    check("q_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    logic [5:0] cexp;
    logic [20:0] cword;
    resetn = 1'b0;
    cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0; commit = 1'b0;
    c_valid = 1'b0; c_addr = '0; c_data = '0; c_commit = 1'b0;
    for (int i = 0; i < N; i++) shadow_m[i] = '0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check("reset_defaults", {25'b0, cfg_ready, busy, done, err, lc_purst, lc_prog, lc_shift_en}, 32'h40);

    run_seq(0, 0, 0, 1'b0, 4'd0, 21'd0);                // 168 zero bits

    wr(4'd7, 21'h1ABCD);
    wr(4'd0, 21'h00001);
    run_seq(P + 50, P + 60, 0, 1'b0, 4'd0, 21'd0);      // rejected commit + back-pressure in SHIFT

    wr(4'd8, 21'h1FFFFF);                               // out of range
    @(negedge clk);
    check("err_one_cycle", {31'b0, err}, 32'd0);
    run_seq(0, 0, 0, 1'b1, 4'd3, 21'h0F0F0);            // same-cycle write + commit

    run_seq(0, 0, P + 50, 1'b0, 4'd0, 21'd0);           // reset mid-shift
    run_seq(0, 0, 0, 1'b0, 4'd0, 21'd0);                // shadow now cleared

    // corner instance: NUM_CELLS = 1, PURST_CYCLES = 1
    @(posedge clk); #1;
    c_valid = 1'b1; c_addr = 1'b1; c_data = 21'h1FFFFF;
    @(posedge clk); #1;
    c_addr = 1'b0; c_data = 21'h12345;
    @(negedge clk);
    check("c_err_badaddr", {31'b0, c_err}, 32'd1);
    @(posedge clk); #1;
    c_valid = 1'b0; c_commit = 1'b1;
    cword = 21'h12345;
    for (int b = W - 1; b >= 0; b--) cq.push_back(cword[b]);
    @(posedge clk); #1;
    c_commit = 1'b0;
    for (int cyc = 1; cyc <= 25; cyc++) begin
      @(negedge clk);
      cexp = {cyc >= 24, cyc <= 23, cyc == 1, (cyc >= 2) && (cyc <= 22), cyc == 23, cyc == 24};
      check($sformatf("c_seq_c%0d", cyc),
            {26'b0, c_ready, c_busy, c_purst, c_shift, c_prog, c_done}, {26'b0, cexp});
      if (cyc >= 2 && cyc <= 22 && cq.size() > 0)
        check("c_sdata", {31'b0, c_sdata}, {31'b0, cq.pop_front()});
      @(posedge clk); #1;
    end
    check("c_q_drained", cq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
